// File: rtl/spi_rx.sv
// spi_rx - receive side of the cs/scl/sda serial link.
//
// The pins are asynchronous to clk. Each one passes through a SYNC_STAGES-deep
// synchroniser, scl rising edges are detected in the clk domain, and sda is
// shifted in MSB-first. Completed words land in a one-entry valid/ready
// holding register.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   cs        in   chip select, active-low, asynchronous
//   scl       in   serial clock, idle low, asynchronous
//   sda       in   serial data, sampled on scl rising edge, asynchronous
//   data_out  out  received word, stable while valid=1
//   valid     out  data_out holds an unconsumed word
//   ready     in   consumer accepts data_out when valid & ready
//   busy      out  frame in progress (synchronised cs low)
//   overrun   out  1-cycle pulse: word completed while holding reg full and not draining
//   frame_err out  1-cycle pulse: cs rose with a partial word collected
`timescale 1ns/1ps
module spi_rx #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  scl,
    input  logic                  sda,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy,
    output logic                  overrun,
    output logic                  frame_err
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] scl_sync_r;
    logic [SYNC_STAGES-1:0] sda_sync_r;
    logic                   scl_prev_r;

    state_t                 state_r;
    logic [DATA_WIDTH-1:0]  shift_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [DATA_WIDTH-1:0]  data_out_r;
    logic                   valid_r;
    logic                   busy_r;
    logic                   overrun_r;
    logic                   frame_err_r;

    logic                   cs_in_s;
    logic                   scl_in_s;
    logic                   sda_in_s;
    logic                   scl_rise_s;
    logic                   done_s;
    logic [DATA_WIDTH-1:0]  word_s;

    // All three pins use the same chain depth, so sda and scl stay aligned.
    assign cs_in_s    = cs_sync_r[SYNC_STAGES-1];
    assign scl_in_s   = scl_sync_r[SYNC_STAGES-1];
    assign sda_in_s   = sda_sync_r[SYNC_STAGES-1];
    assign scl_rise_s = scl_in_s & ~scl_prev_r;

    // Synchroniser chains and the scl edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_sync_r  <= {SYNC_STAGES{1'b1}};
            scl_sync_r <= {SYNC_STAGES{1'b0}};
            sda_sync_r <= {SYNC_STAGES{1'b0}};
            scl_prev_r <= 1'b0;
        end else begin
            cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0],  cs};
            scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda};
            scl_prev_r <= scl_in_s;
        end
    end

    // Detect word completion: last bit shifted on an scl edge while cs stays low.
    // A cs rise in the same cycle wins, so that edge is ignored.
    always_comb begin
        word_s = {shift_r[DATA_WIDTH-2:0], sda_in_s};
        done_s = 1'b0;
        if ((state_r == SHIFT) && !cs_in_s && scl_rise_s && (bit_cnt_r == LAST_BIT)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Frame FSM, shifter, and valid/ready holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            shift_r     <= {DATA_WIDTH{1'b0}};
            bit_cnt_r   <= {CNT_W{1'b0}};
            data_out_r  <= {DATA_WIDTH{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;

            case (state_r)
                IDLE: begin
                    bit_cnt_r <= {CNT_W{1'b0}};
                    if (!cs_in_s) begin
                        state_r <= SHIFT;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cs_in_s) begin
                        // Partial word is discarded; flag it only if bits were taken.
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        bit_cnt_r   <= {CNT_W{1'b0}};
                        frame_err_r <= (bit_cnt_r != {CNT_W{1'b0}});
                    end else begin
                        busy_r <= 1'b1;
                        if (scl_rise_s) begin
                            shift_r   <= word_s;
                            bit_cnt_r <= done_s ? {CNT_W{1'b0}} : (bit_cnt_r + CNT_W'(1));
                        end else begin
                            shift_r   <= shift_r;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    busy_r    <= 1'b0;
                    bit_cnt_r <= {CNT_W{1'b0}};
                end
            endcase

            // A draining consumer frees the slot in the same cycle a new word lands.
            if (done_s) begin
                if (!valid_r || ready) begin
                    data_out_r <= word_s;
                    valid_r    <= 1'b1;
                end else begin
                    overrun_r  <= 1'b1;
                end
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign data_out  = data_out_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_spi_rx.sv
// tb_spi_rx - scoreboard bench for spi_rx: stimulus pushes expected words into
// a queue, a negedge monitor pops and compares on every valid&ready handshake
// and counts overrun/frame_err pulses.
`timescale 1ns/1ps
module tb_spi_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       scl;
    logic       sda;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       busy;
    logic       overrun;
    logic       frame_err;

    int         checks = 0;
    int         errors = 0;
    int         ovr_cnt = 0;
    int         ferr_cnt = 0;
    int         base_o;
    int         base_f;
    logic [7:0] exp_q[$];
    logic [7:0] mon_exp;

    always #5 clk = ~clk;

    spi_rx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .scl(scl), .sda(sda),
        .data_out(data_out), .valid(valid), .ready(ready), .busy(busy),
        .overrun(overrun), .frame_err(frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop/compare on each handshake, count status pulses.
    always @(negedge clk) begin
        if (reset) begin
            if (overrun)   ovr_cnt++;
            if (frame_err) ferr_cnt++;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: actual=%0h expected=none", data_out);
                end else begin
                    mon_exp = exp_q.pop_front();
                    chk("word", {24'd0, data_out}, {24'd0, mon_exp});
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode 0: plain, 1: pulse ready in completion cycle of last bit, 2: check latency on last bit
    task automatic send_bits(input logic [7:0] d, input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            sda = d[7-i];
            scl = 1'b0;
            tick(3);
            scl = 1'b1;
            if (i == n - 1 && mode == 1) begin
                tick(2); ready = 1'b1;
                tick(1); ready = 1'b0;
                tick(1);
            end else if (i == n - 1 && mode == 2) begin
                tick(2);
                chk("lat_early_valid", {31'd0, valid}, 32'd0);
                tick(1);
                chk("lat_valid", {31'd0, valid}, 32'd1);
                chk("lat_data", {24'd0, data_out}, {24'd0, d});
                tick(1);
            end else begin
                tick(4);
            end
        end
        scl = 1'b0;
    endtask

    task automatic frame_start();
        cs = 1'b0;
        tick(3);
    endtask

    task automatic frame_end();
        scl = 1'b0;
        tick(3);
        cs = 1'b1;
        tick(4);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick(1);
        end
        chk(name, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; cs = 1'b1; scl = 1'b0; sda = 1'b0; ready = 1'b0;
        tick(3);
        chk("rst_data", {24'd0, data_out}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        reset = 1'b1;
        tick(2);

        // 1: fill holding reg, then reset mid-frame after 5 bits
        frame_start();
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_bits(8'h5A, 8, 0);
        send_bits(8'hFF, 5, 0);
        reset = 1'b0;
        #1;
        chk("t1_rst_data", {24'd0, data_out}, 32'd0);
        chk("t1_rst_valid", {31'd0, valid}, 32'd0);
        chk("t1_rst_busy", {31'd0, busy}, 32'd0);
        chk("t1_rst_overrun", {31'd0, overrun}, 32'd0);
        chk("t1_rst_frame_err", {31'd0, frame_err}, 32'd0);
        cs = 1'b1; scl = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        base_f = ferr_cnt;
        frame_start();
        send_bits(8'hA5, 8, 2);
        frame_end();
        chk("t1_frame_err", ferr_cnt - base_f, 32'd0);
        exp_q.push_back(8'hA5);
        ready = 1'b1;
        drain("t1_drain");

        // 2: back-to-back words in one frame, ready held high
        base_o = ovr_cnt; base_f = ferr_cnt;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        frame_start();
        send_bits(8'h3C, 8, 0);
        send_bits(8'hC3, 8, 0);
        frame_end();
        drain("t2_drain");
        chk("t2_overrun", ovr_cnt - base_o, 32'd0);
        chk("t2_frame_err", ferr_cnt - base_f, 32'd0);

        // 3: overrun with ready low
        ready = 1'b0;
        base_o = ovr_cnt;
        exp_q.push_back(8'h11);
        frame_start();
        send_bits(8'h11, 8, 0);
        send_bits(8'h22, 8, 0);
        frame_end();
        chk("t3_overrun", ovr_cnt - base_o, 32'd1);
        chk("t3_data", {24'd0, data_out}, 32'h11);
        chk("t3_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        tick(1);
        chk("t3_valid_fall", {31'd0, valid}, 32'd0);
        chk("t3_data_keep", {24'd0, data_out}, 32'h11);
        drain("t3_drain");

        // 4: ready pulsed in the cycle the second word completes
        ready = 1'b0;
        base_o = ovr_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        frame_start();
        send_bits(8'h11, 8, 0);
        send_bits(8'h22, 8, 1);
        frame_end();
        chk("t4_overrun", ovr_cnt - base_o, 32'd0);
        chk("t4_data", {24'd0, data_out}, 32'h22);
        chk("t4_valid", {31'd0, valid}, 32'd1);
        ready = 1'b1;
        drain("t4_drain");

        // 5: partial frame, then clean frame
        base_f = ferr_cnt;
        frame_start();
        send_bits(8'hA0, 3, 0);
        frame_end();
        chk("t5_frame_err", ferr_cnt - base_f, 32'd1);
        chk("t5_valid", {31'd0, valid}, 32'd0);
        exp_q.push_back(8'hFF);
        frame_start();
        send_bits(8'hFF, 8, 0);
        frame_end();
        drain("t5_drain");
        chk("t5_frame_err_after", ferr_cnt - base_f, 32'd1);

        // 6: all byte values in one frame at ~14 MHz scl
        base_o = ovr_cnt; base_f = ferr_cnt;
        for (int b = 0; b < 256; b++) exp_q.push_back(8'(b));
        frame_start();
        for (int b = 0; b < 256; b++) send_bits(8'(b), 8, 0);
        frame_end();
        drain("t6_drain");
        chk("t6_overrun", ovr_cnt - base_o, 32'd0);
        chk("t6_frame_err", ferr_cnt - base_f, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
